// File: rtl/sram_req_adapter_if.sv
// ----------------------------------------------------------------------------
// sram_req_adapter_if
//
// Purpose:
//   Bundles the signals around sram_req_adapter into one interface:
//   - the request stream from an engine,
//   - the read-response stream back to that engine,
//   - the single-port SRAM wrapper port.
//
// Modports:
//   slave  - the adapter. It receives requests, rsp_ready and SRAM read data.
//            It drives req_ready, the response stream and the SRAM controls.
//   master - the surrounding environment (engine plus SRAM wrapper), which
//            has the opposite view of every signal.
//
// Signals:
//   req_valid/req_ready/req_write/req_addr/req_wdata/req_wstrb
//       Request stream. A request transfers on valid & ready.
//   rsp_valid/rsp_ready/rsp_rdata
//       Read-response stream, returned in request order.
//   sram_cen/sram_wen/sram_addr/sram_wdata/sram_wstrb
//       SRAM port controls. Enables are active high.
//   sram_rdata
//       SRAM read data, valid the cycle after a read access.
// ----------------------------------------------------------------------------
interface sram_req_adapter_if #(
   parameter int AW = 10,
   parameter int DW = 128,
   parameter int SW = DW / 8
);
   // request stream
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [SW-1:0] req_wstrb;

   // read-response stream
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;

   // SRAM wrapper port
   logic          sram_cen;
   logic          sram_wen;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [SW-1:0] sram_wstrb;
   logic [DW-1:0] sram_rdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
      input  rsp_ready,
      input  sram_rdata,
      output req_ready,
      output rsp_valid, rsp_rdata,
      output sram_cen, sram_wen, sram_addr, sram_wdata, sram_wstrb
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb,
      output rsp_ready,
      output sram_rdata,
      input  req_ready,
      input  rsp_valid, rsp_rdata,
      input  sram_cen, sram_wen, sram_addr, sram_wdata, sram_wstrb
   );

endinterface

// File: rtl/sram_req_adapter.sv
// ----------------------------------------------------------------------------
// sram_req_adapter
//
// Purpose:
//   Requester-side controller for one 1024x128b single-port SRAM bank wrapper.
//   It turns a valid/ready request stream into SRAM port cycles.
//
//   Writes:
//   - Always accepted.
//   - No response is generated.
//
//   Reads:
//   - The SRAM returns data exactly one cycle after the access.
//   - That data is captured unconditionally into a small response FIFO.
//   - A credit check on reads keeps the FIFO from overflowing, so the
//     response consumer may stall freely without losing data.
//   - Responses come back strictly in request order.
//
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset (released synchronously upstream)
//   bus   - sram_req_adapter_if.slave
//           (request stream, response stream, SRAM port)
//   idle  - high when no read is in flight and the response FIFO is empty
//
// Parameters:
//   AW        - word address width (1024 entries)
//   DW        - data width
//   SW        - byte-strobe width
//   RSP_DEPTH - response FIFO entries (>= 2); also the read credit limit
// ----------------------------------------------------------------------------
module sram_req_adapter #(
   parameter int AW        = 10,
   parameter int DW        = 128,
   parameter int SW        = DW / 8,
   parameter int RSP_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   sram_req_adapter_if.slave    bus,
   output logic                 idle
);

   // ------------------------------------------------------------------------
   // Widths
   //   PW: FIFO pointer width
   //   CW: FIFO count width (holds 0..RSP_DEPTH)
   //   OW: occupancy width (count plus the in-flight read)
   // ------------------------------------------------------------------------
   localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int OW = CW + 1;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic          inflight_reg;
   logic          inflight_next;
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] rd_ptr_next;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   // Response storage. It has no reset: validity is tracked by count_reg alone.
   logic [DW-1:0] fifo_mem [RSP_DEPTH];

   // ------------------------------------------------------------------------
   // Handshake and credit
   // ------------------------------------------------------------------------
   logic          push;
   logic          pop;
   logic          rsp_valid_int;
   logic [OW-1:0] occ;
   logic [OW-1:0] occ_after_pop;
   logic          read_ok;
   logic          req_ready_int;
   logic          accept;
   logic          rd_accept;

   // Pointer advance with wrap. This works for any depth, not only powers of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(RSP_DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // Read data from the SRAM always lands one cycle after a read access.
   // It is pushed whenever a read was issued in the previous cycle.
   assign push          = inflight_reg;
   assign rsp_valid_int = (count_reg != '0);
   assign pop           = rsp_valid_int & bus.rsp_ready;

   // Occupancy counts the FIFO entries plus the read whose data has not yet
   // been captured.
   // - A pop in the same cycle frees a slot before the new read's data
   //   arrives, so it is credited back immediately.
   // - This crediting is what lets RSP_DEPTH=2 sustain one read per cycle
   //   with rsp_ready held high.
   // - occ never underflows: pop needs count_reg != 0.
   assign occ           = OW'(count_reg) + OW'(inflight_reg);
   assign occ_after_pop = occ - OW'(pop);
   assign read_ok       = (occ_after_pop < OW'(RSP_DEPTH));

   // Writes never produce a response, so they bypass the credit check.
   assign req_ready_int = bus.req_write | read_ok;
   assign accept        = bus.req_valid & req_ready_int;
   assign rd_accept     = accept & ~bus.req_write;

   // ------------------------------------------------------------------------
   // SRAM port drive
   //   Combinational from the request. The SRAM samples it at the same edge
   //   that completes the handshake.
   // ------------------------------------------------------------------------
   assign bus.sram_cen   = accept;
   assign bus.sram_wen   = accept & bus.req_write;
   assign bus.sram_addr  = bus.req_addr;
   assign bus.sram_wdata = bus.req_wdata;

   // Strobes are forced low on anything that is not a write cycle.
   // The SRAM therefore never sees stray byte enables on reads.
   generate
      for (genvar gi = 0; gi < SW; gi++) begin : g_wstrb
         assign bus.sram_wstrb[gi] = bus.req_wstrb[gi] & bus.sram_wen;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Response side outputs
   // ------------------------------------------------------------------------
   assign bus.req_ready = req_ready_int;
   assign bus.rsp_valid = rsp_valid_int;
   assign bus.rsp_rdata = fifo_mem[rd_ptr_reg];
   assign idle          = ~inflight_reg & (count_reg == '0);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      // A read accepted this cycle keeps the flag set for the next cycle,
      // even while the previous read's data is being pushed.
      inflight_next = rd_accept;
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;

      if (push) begin
         wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
         rd_ptr_next = ptr_inc(rd_ptr_reg);
      end

      // A simultaneous push and pop leaves the count unchanged.
      unique case ({push, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   // ------------------------------------------------------------------------
   // Control registers
   //   Reset discards any in-flight read and all FIFO contents.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_reg <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
      end else begin
         inflight_reg <= inflight_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
      end
   end

   // ------------------------------------------------------------------------
   // Response storage write
   //   push is derived from inflight_reg, which is held low during reset.
   //   The storage therefore needs no reset term of its own.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= bus.sram_rdata;
      end
   end

endmodule

// File: tb/tb_sram_req_adapter.sv
// ----------------------------------------------------------------------------
// tb_sram_req_adapter
//
// Purpose:
//   Self-checking bench for sram_req_adapter.
//
// Structure:
//   - A behavioural 1024x128 SRAM with a one-cycle read latency is attached
//     to the SRAM port.
//   - A reference memory is updated at every accepted write.
//   - Each accepted read pushes the reference contents onto a scoreboard
//     queue.
//   - Each popped response is compared against the head of that queue.
//
// Timing:
//   - Inputs are driven just after the falling edge.
//   - Handshakes are evaluated 1 ns later, i.e. exactly what the next rising
//     edge will see.
// ----------------------------------------------------------------------------
module tb_sram_req_adapter;

   localparam int AW        = 10;
   localparam int DW        = 128;
   localparam int SW        = DW / 8;
   localparam int RSP_DEPTH = 2;
   localparam int NW        = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic idle;

   sram_req_adapter_if #(.AW(AW), .DW(DW), .SW(SW)) bus ();

   sram_req_adapter #(
      .AW(AW), .DW(DW), .SW(SW), .RSP_DEPTH(RSP_DEPTH)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .idle (idle)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Behavioural SRAM: byte-masked write, registered one-cycle read
   // ------------------------------------------------------------------------
   logic [DW-1:0] sram_mem [NW];
   logic [DW-1:0] ref_mem  [NW];

   always @(posedge clk) begin
      if (bus.sram_cen) begin
         if (bus.sram_wen) begin
            for (int b = 0; b < SW; b++) begin
               if (bus.sram_wstrb[b]) begin
                  sram_mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
               end
            end
         end else begin
            bus.sram_rdata <= sram_mem[bus.sram_addr];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Scoreboard state and counters
   // ------------------------------------------------------------------------
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] last_rsp;
   int            n_vec = 0;
   int            n_err = 0;
   int            n_acc = 0;
   int            n_pop = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
      bus.req_valid = v;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_wstrb = s;
      #1;
   endtask

   task automatic drive_none();
      // Fields are deliberately non-zero: they must be ignored.
      drive(1'b0, 1'b1, AW'($urandom_range(0, NW - 1)), {4{$urandom}}, '1);
   endtask

   // Evaluate the current cycle's handshakes, then advance to the next falling edge.
   task automatic tick();
      #1;
      if (bus.req_valid && bus.req_ready) begin
         n_acc++;
         if (bus.req_write) begin
            for (int b = 0; b < SW; b++) begin
               if (bus.req_wstrb[b]) begin
                  ref_mem[bus.req_addr][8*b +: 8] = bus.req_wdata[8*b +: 8];
               end
            end
            $display("acc wr addr=%0d strb=%h data=%h", bus.req_addr,
                     bus.req_wstrb, bus.req_wdata);
         end else begin
            exp_q.push_back(ref_mem[bus.req_addr]);
            $display("acc rd addr=%0d", bus.req_addr);
         end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
         n_pop++;
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", DW'(bus.rsp_valid), DW'(0));
         end else begin
            last_rsp = bus.rsp_rdata;
            $display("rsp data=%h", bus.rsp_rdata);
            chk("rsp_data", bus.rsp_rdata, exp_q.pop_front());
         end
      end
      @(negedge clk);
   endtask

   // Bounded drain: wait until the DUT is idle and every expected response has arrived.
   task automatic drain(input int budget);
      int n;
      n = 0;
      bus.rsp_ready = 1'b1;
      drive_none();
      while (!(idle && exp_q.size() == 0) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_idle", DW'(idle), DW'(1));
      chk("drain_queue", DW'(exp_q.size()), DW'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int a0;
      int p0;
      logic [DW-1:0] d3;

      for (int i = 0; i < NW; i++) begin
         sram_mem[i] = {4{32'hC0DE0000 | 32'(i)}};
         ref_mem[i]  = {4{32'hC0DE0000 | 32'(i)}};
      end
      bus.rsp_ready = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0);
      repeat (2) @(negedge clk);

      // -- reset state ------------------------------------------------------
      chk("rst_rsp_valid", DW'(bus.rsp_valid), DW'(0));
      chk("rst_idle", DW'(idle), DW'(1));
      chk("rst_req_ready", DW'(bus.req_ready), DW'(1));
      chk("rst_sram_cen", DW'(bus.sram_cen), DW'(0));
      rst = 1'b0;
      @(negedge clk);

      // -- req_valid=0 leaves the SRAM alone -------------------------------
      drive_none();
      chk("novalid_cen", DW'(bus.sram_cen), DW'(0));
      chk("novalid_wstrb", DW'(bus.sram_wstrb), DW'(0));
      tick();

      // -- write then read addr 5, latency 2 -------------------------------
      drive(1'b1, 1'b1, 10'd5, 128'h0123456789ABCDEF0123456789ABCDEF, '1);
      chk("wr5_wen", DW'(bus.sram_wen), DW'(1));
      chk("wr5_wstrb", DW'(bus.sram_wstrb), DW'(16'hFFFF));
      tick();
      drive(1'b1, 1'b0, 10'd5, '0, '1);
      chk("rd5_cen", DW'(bus.sram_cen), DW'(1));
      chk("rd5_wstrb", DW'(bus.sram_wstrb), DW'(0));
      tick();
      drive_none();
      chk("rd5_t1_valid", DW'(bus.rsp_valid), DW'(0));
      tick();
      chk("rd5_t2_valid", DW'(bus.rsp_valid), DW'(1));
      tick();
      chk("rd5_data", last_rsp, 128'h0123456789ABCDEF0123456789ABCDEF);

      // -- partial strobe on addr 7, zero-strobe write on addr 9 -----------
      drive(1'b1, 1'b1, 10'd7, '1, '1);
      tick();
      drive(1'b1, 1'b1, 10'd7, '0, 16'h0001);
      tick();
      drive(1'b1, 1'b0, 10'd7, '0, '0);
      tick();
      drain(20);
      chk("rd7_data", last_rsp, {{15{8'hFF}}, 8'h00});
      drive(1'b1, 1'b1, 10'd9, '1, '0);
      chk("wr9_cen", DW'(bus.sram_cen), DW'(1));
      chk("wr9_wstrb", DW'(bus.sram_wstrb), DW'(0));
      tick();
      drive(1'b1, 1'b0, 10'd9, '0, '0);
      tick();
      drain(20);
      chk("rd9_data", last_rsp, {4{32'hC0DE0009}});

      // -- 16 back-to-back reads, no bubbles -------------------------------
      a0 = n_acc;
      p0 = n_pop;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, AW'(i), '0, '0);
         chk("b2b_ready", DW'(bus.req_ready), DW'(1));
         tick();
      end
      chk("b2b_accepts", DW'(n_acc - a0), DW'(16));
      drive_none();
      tick();
      tick();
      chk("b2b_pops", DW'(n_pop - p0), DW'(16));
      drain(20);

      // -- backpressure: only RSP_DEPTH reads accepted, writes still go ----
      bus.rsp_ready = 1'b0;
      a0 = n_acc;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, AW'(20 + i), '0, '0);
         tick();
      end
      chk("bp_accepts", DW'(n_acc - a0), DW'(2));
      drive(1'b1, 1'b0, 10'd22, '0, '0);
      chk("bp_rd_ready", DW'(bus.req_ready), DW'(0));
      chk("bp_rd_cen", DW'(bus.sram_cen), DW'(0));
      drive(1'b1, 1'b1, 10'd30, {4{32'h5A5A1234}}, '1);
      chk("bp_wr_ready", DW'(bus.req_ready), DW'(1));
      tick();
      chk("bp_rsp_valid", DW'(bus.rsp_valid), DW'(1));
      drain(20);
      drive(1'b1, 1'b0, 10'd30, '0, '0);
      chk("resume_ready", DW'(bus.req_ready), DW'(1));
      tick();
      drain(20);

      // -- reset with one read in flight and one entry held ----------------
      bus.rsp_ready = 1'b0;
      drive(1'b1, 1'b0, 10'd40, '0, '0);
      tick();
      drive(1'b1, 1'b0, 10'd41, '0, '0);
      tick();
      drive_none();
      chk("prerst_valid", DW'(bus.rsp_valid), DW'(1));
      chk("prerst_idle", DW'(idle), DW'(0));
      rst = 1'b1;
      #1;
      chk("midrst_valid", DW'(bus.rsp_valid), DW'(0));
      chk("midrst_idle", DW'(idle), DW'(1));
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("postrst_valid", DW'(bus.rsp_valid), DW'(0));
         tick();
      end
      drive(1'b1, 1'b0, 10'd41, '0, '0);
      tick();
      drain(20);

      // -- read-after-write on consecutive cycles --------------------------
      d3 = {$urandom, $urandom, $urandom, $urandom};
      drive(1'b1, 1'b1, 10'd3, d3, '1);
      tick();
      drive(1'b1, 1'b0, 10'd3, '1, '1);
      chk("raw_rd_wstrb", DW'(bus.sram_wstrb), DW'(0));
      chk("raw_rd_wen", DW'(bus.sram_wen), DW'(0));
      tick();
      drain(20);
      chk("raw_data", last_rsp, d3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
